// File: rtl/alert_display_arbiter_pkg.sv
// Shared definitions for the alert/display arbiter: state encoding,
// alert source codes and a small sizing helper.
package alert_display_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALARM  = 2'd1,
    ST_CD     = 2'd2,
    ST_SNOOZE = 2'd3
  } state_t;

  localparam logic [1:0] SRC_NONE   = 2'd0;
  localparam logic [1:0] SRC_ALARM  = 2'd1;
  localparam logic [1:0] SRC_CD     = 2'd2;
  localparam logic [1:0] SRC_SNOOZE = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alert_display_arbiter_tick_timer.sv
// Seconds counter for alert and snooze timeouts; expire flags the tick that
// completes the programmed number of seconds.
module tick_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_sec_tick,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, tested inside the block.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && i_sec_tick) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_expire = i_sec_tick && (r_count == (i_limit - CNT_W'(1)));

endmodule

// File: rtl/alert_display_arbiter.sv
// Arbitrates the 7-seg display and LED[0] between the user clock mode and the
// alarm / countdown alerts, with timeout, snooze and edit-time deferral.
module alert_display_arbiter
  import alert_display_arbiter_pkg::*;
#(
  parameter int ALERT_SECS  = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int SNOOZE_MAX  = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        secTick,
  input  logic [31:0] userOut,
  input  logic        editing,
  input  logic [31:0] alarmTime,
  input  logic        alarmHit,
  input  logic        cdDone,
  input  logic        ackBtn,
  input  logic        snoozeBtn,
  output logic [31:0] dispOut,
  output logic [1:0]  alertSrc,
  output logic        ledBlink,
  output logic        alertActive
);

  localparam int CNT_W = $clog2(max_int(ALERT_SECS, SNOOZE_SECS) + 1);
  localparam int SNZ_W = (SNOOZE_MAX < 1) ? 1 : $clog2(SNOOZE_MAX + 1);
  localparam logic [CNT_W-1:0] ALERT_LIM  = CNT_W'(ALERT_SECS);
  localparam logic [CNT_W-1:0] SNOOZE_LIM = CNT_W'(SNOOZE_SECS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [SNZ_W-1:0] SNZ_LIM    = SNZ_W'(SNOOZE_MAX);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_pend_alarm;
  logic             r_pend_cd;
  logic [SNZ_W-1:0] r_snooze_used;
  logic             w_req_alarm;
  logic             w_req_cd;
  logic             w_enter;
  logic             w_clear;
  logic             w_expire;
  logic             w_blink_lit;
  logic [CNT_W-1:0] w_sec_cnt;
  logic [CNT_W-1:0] w_limit;

  assign w_req_alarm = r_pend_alarm | alarmHit;
  assign w_req_cd    = r_pend_cd | cdDone;
  assign w_enter     = (w_state_nxt != r_state);
  assign w_clear     = w_enter || (r_state == ST_IDLE);
  assign w_limit     = (r_state == ST_SNOOZE) ? SNOOZE_LIM : ALERT_LIM;

  tick_timer #(.CNT_W(CNT_W)) u_tick_timer (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_clear    (w_clear),
    .i_enable   (r_state != ST_IDLE),
    .i_sec_tick (secTick),
    .i_limit    (w_limit),
    .o_count    (w_sec_cnt),
    .o_expire   (w_expire)
  );

  // The LED is lit whenever the elapsed-second count after this edge is even.
  assign w_blink_lit = (((w_sec_cnt & CNT_ONE) != '0) == secTick);

  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!editing && w_req_alarm)   w_state_nxt = ST_ALARM;
        else if (!editing && w_req_cd) w_state_nxt = ST_CD;
      end
      ST_ALARM: begin
        if (ackBtn || w_expire) w_state_nxt = ST_IDLE;
        else if (snoozeBtn)     w_state_nxt = (r_snooze_used < SNZ_LIM) ? ST_SNOOZE : ST_IDLE;
      end
      ST_SNOOZE: begin
        if (ackBtn)        w_state_nxt = ST_IDLE;
        else if (w_req_cd) w_state_nxt = ST_CD;
        else if (w_expire) w_state_nxt = ST_ALARM;
      end
      ST_CD: begin
        if (ackBtn || snoozeBtn || w_expire) w_state_nxt = ST_IDLE;
        else if (w_req_alarm)                w_state_nxt = ST_ALARM;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state       <= ST_IDLE;
      r_pend_alarm  <= 1'b0;
      r_pend_cd     <= 1'b0;
      r_snooze_used <= '0;
      dispOut       <= '0;
      alertSrc      <= SRC_NONE;
      ledBlink      <= 1'b0;
      alertActive   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // A pulse for the alert already in service is merged and dropped.
      if (w_enter && w_state_nxt == ST_ALARM)
        r_pend_alarm <= 1'b0;
      else if (r_state == ST_SNOOZE && w_state_nxt == ST_CD)
        r_pend_alarm <= 1'b1;
      else if (alarmHit && r_state != ST_ALARM && r_state != ST_SNOOZE)
        r_pend_alarm <= 1'b1;

      if (w_enter && w_state_nxt == ST_CD)
        r_pend_cd <= 1'b0;
      else if (r_state == ST_CD && w_state_nxt == ST_ALARM)
        r_pend_cd <= 1'b1;
      else if (cdDone && r_state != ST_CD)
        r_pend_cd <= 1'b1;

      // Snoozes survive a countdown interruption; only alarm exits reset them.
      if (r_state == ST_ALARM && w_state_nxt == ST_SNOOZE)
        r_snooze_used <= r_snooze_used + SNZ_W'(1);
      else if (w_state_nxt == ST_IDLE && (r_state == ST_ALARM || r_state == ST_SNOOZE))
        r_snooze_used <= '0;

      case (w_state_nxt)
        ST_ALARM: begin
          dispOut     <= alarmTime;
          alertSrc    <= SRC_ALARM;
          ledBlink    <= w_enter ? 1'b1 : w_blink_lit;
          alertActive <= 1'b1;
        end
        ST_CD: begin
          dispOut     <= '0;
          alertSrc    <= SRC_CD;
          ledBlink    <= w_enter ? 1'b1 : w_blink_lit;
          alertActive <= 1'b1;
        end
        ST_SNOOZE: begin
          dispOut     <= userOut;
          alertSrc    <= SRC_SNOOZE;
          ledBlink    <= 1'b0;
          alertActive <= 1'b0;
        end
        default: begin
          dispOut     <= userOut;
          alertSrc    <= SRC_NONE;
          ledBlink    <= 1'b0;
          alertActive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alert_display_arbiter.sv
// Directed bench for alert_display_arbiter: a behavioural model tracks the
// expected outputs every cycle, and literal checks pin key points of the story.
module tb_alert_display_arbiter;

  localparam int A_SECS = 5;
  localparam int S_SECS = 3;
  localparam int S_MAX  = 2;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_HIT  = 5'b00001;
  localparam logic [4:0] P_CD   = 5'b00010;
  localparam logic [4:0] P_ACK  = 5'b00100;
  localparam logic [4:0] P_SNZ  = 5'b01000;
  localparam logic [4:0] P_SEC  = 5'b10000;

  localparam int M_IDLE = 0, M_ALARM = 1, M_CD = 2, M_SNOOZE = 3;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        secTick = 1'b0, editing = 1'b0;
  logic        alarmHit = 1'b0, cdDone = 1'b0, ackBtn = 1'b0, snoozeBtn = 1'b0;
  logic [31:0] userOut = '0, alarmTime = '0;
  logic [31:0] dispOut;
  logic [1:0]  alertSrc;
  logic        ledBlink, alertActive;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  alert_display_arbiter #(
    .ALERT_SECS (A_SECS),
    .SNOOZE_SECS(S_SECS),
    .SNOOZE_MAX (S_MAX)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .secTick    (secTick),
    .userOut    (userOut),
    .editing    (editing),
    .alarmTime  (alarmTime),
    .alarmHit   (alarmHit),
    .cdDone     (cdDone),
    .ackBtn     (ackBtn),
    .snoozeBtn  (snoozeBtn),
    .dispOut    (dispOut),
    .alertSrc   (alertSrc),
    .ledBlink   (ledBlink),
    .alertActive(alertActive)
  );

  // Model of the arbiter: mode, pending flags, elapsed seconds, snoozes used.
  int          m_mode = M_IDLE;
  bit          m_pa = 0, m_pc = 0;
  int          m_secs = 0, m_snz = 0;
  logic [31:0] e_disp = '0;
  logic [1:0]  e_src = '0;
  logic        e_led = 1'b0, e_act = 1'b0;
  bit          cmp_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function void model_step();
    bit want_a, want_c, tmo;
    int nm;
    if (Rst) begin
      m_mode = M_IDLE; m_pa = 0; m_pc = 0; m_secs = 0; m_snz = 0;
      e_disp = '0; e_src = '0; e_led = 1'b0; e_act = 1'b0;
      return;
    end
    want_a = m_pa || alarmHit;
    want_c = m_pc || cdDone;
    tmo    = secTick && (m_secs == ((m_mode == M_SNOOZE) ? S_SECS : A_SECS) - 1);
    nm     = m_mode;
    if (alarmHit && m_mode != M_ALARM && m_mode != M_SNOOZE) m_pa = 1;
    if (cdDone && m_mode != M_CD) m_pc = 1;
    case (m_mode)
      M_IDLE: if (!editing) begin
        if (want_a) nm = M_ALARM;
        else if (want_c) nm = M_CD;
      end
      M_ALARM: begin
        if (ackBtn || tmo) nm = M_IDLE;
        else if (snoozeBtn) begin
          if (m_snz < S_MAX) begin nm = M_SNOOZE; m_snz++; end
          else nm = M_IDLE;
        end
      end
      M_CD: begin
        if (ackBtn || snoozeBtn || tmo) nm = M_IDLE;
        else if (want_a) begin nm = M_ALARM; m_pc = 1; end
      end
      default: begin
        if (ackBtn) nm = M_IDLE;
        else if (want_c) begin nm = M_CD; m_pa = 1; end
        else if (tmo) nm = M_ALARM;
      end
    endcase
    if (nm != m_mode) begin
      m_secs = 0;
      if (nm == M_ALARM) m_pa = 0;
      if (nm == M_CD) m_pc = 0;
      if (nm == M_IDLE && m_mode != M_CD) m_snz = 0;
      e_led = (nm == M_ALARM || nm == M_CD);
    end else begin
      if (nm != M_IDLE && secTick) m_secs++;
      e_led = (nm == M_ALARM || nm == M_CD) ? (e_led ^ secTick) : 1'b0;
    end
    m_mode = nm;
    case (nm)
      M_ALARM: begin e_disp = alarmTime; e_src = 2'd1; e_act = 1'b1; end
      M_CD:    begin e_disp = '0;        e_src = 2'd2; e_act = 1'b1; end
      M_SNOOZE:begin e_disp = userOut;   e_src = 2'd3; e_act = 1'b0; end
      default: begin e_disp = userOut;   e_src = 2'd0; e_act = 1'b0; end
    endcase
  endfunction

  always @(posedge Clk) begin
    #2;
    if (cmp_en) begin
      check("model_dispOut", dispOut, e_disp);
      check("model_alertSrc", {30'd0, alertSrc}, {30'd0, e_src});
      check("model_ledBlink", {31'd0, ledBlink}, {31'd0, e_led});
      check("model_alertActive", {31'd0, alertActive}, {31'd0, e_act});
    end
  end

  task automatic tick(input logic [4:0] p);
    {secTick, snoozeBtn, ackBtn, cdDone, alarmHit} = p;
    model_step();
    cmp_en = 1;
    @(posedge Clk);
    #3;
    {secTick, snoozeBtn, ackBtn, cdDone, alarmHit} = 5'b00000;
  endtask

  task automatic ticks(input int n, input logic [4:0] p);
    repeat (n) tick(p);
  endtask

  initial begin
    Rst = 1'b1; userOut = 32'd3600; alarmTime = 32'd25200; editing = 1'b0;
    ticks(2, P_NONE);
    check("rst_disp", dispOut, 32'd0);
    check("rst_src", alertSrc, 2'd0);
    Rst = 1'b0;
    tick(P_NONE);
    check("first_disp", dispOut, 32'd3600);
    check("first_src", alertSrc, 2'd0);

    // Alarm with blink and auto-dismiss on the fifth second
    tick(P_HIT);
    check("alarm_disp", dispOut, 32'd25200);
    check("alarm_src", alertSrc, 2'd1);
    check("alarm_led", ledBlink, 1'b1);
    check("alarm_active", alertActive, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick(P_NONE);
      tick(P_SEC);
      check($sformatf("blink_%0d", k), ledBlink, (k % 2 == 1) ? 1'b0 : 1'b1);
      check($sformatf("blink_src_%0d", k), alertSrc, 2'd1);
    end
    tick(P_SEC);
    check("auto_src", alertSrc, 2'd0);
    check("auto_disp", dispOut, 32'd3600);
    check("auto_led", ledBlink, 1'b0);

    // Snooze twice, third snooze dismisses, count reset for next alarm
    userOut = 32'h0012_3456;
    tick(P_HIT);
    tick(P_SNZ);
    check("snz1_src", alertSrc, 2'd3);
    check("snz1_disp", dispOut, 32'h0012_3456);
    ticks(2, P_SEC);
    check("snz1_hold", alertSrc, 2'd3);
    tick(P_SEC);
    check("resume1_src", alertSrc, 2'd1);
    check("resume1_led", ledBlink, 1'b1);
    tick(P_SNZ);
    check("snz2_src", alertSrc, 2'd3);
    ticks(3, P_SEC);
    check("resume2_src", alertSrc, 2'd1);
    tick(P_SNZ);
    check("snz3_dismiss", alertSrc, 2'd0);
    tick(P_HIT);
    tick(P_SNZ);
    check("snz_count_reset", alertSrc, 2'd3);
    tick(P_ACK);
    check("snz_ack", alertSrc, 2'd0);

    // Alarm beats countdown on the same cycle
    tick(P_HIT | P_CD);
    check("both_alarm", alertSrc, 2'd1);
    tick(P_ACK);
    check("both_idle", alertSrc, 2'd0);
    tick(P_NONE);
    check("both_cd_src", alertSrc, 2'd2);
    check("both_cd_disp", dispOut, 32'd0);
    tick(P_ACK);

    // Editing defers countdown entry; snooze acts as ack in CD
    editing = 1'b1;
    tick(P_CD);
    check("edit_src", alertSrc, 2'd0);
    check("edit_disp", dispOut, 32'h0012_3456);
    ticks(2, P_NONE);
    check("edit_hold", alertSrc, 2'd0);
    editing = 1'b0;
    tick(P_NONE);
    check("edit_release", alertSrc, 2'd2);
    tick(P_SNZ);
    check("cd_snz_ack", alertSrc, 2'd0);

    // Alarm pre-empts countdown; countdown restarts fresh afterwards
    tick(P_CD);
    ticks(2, P_SEC);
    tick(P_HIT);
    check("preempt_src", alertSrc, 2'd1);
    check("preempt_disp", dispOut, 32'd25200);
    tick(P_ACK);
    check("preempt_idle", alertSrc, 2'd0);
    tick(P_NONE);
    check("restart_cd", alertSrc, 2'd2);
    ticks(4, P_SEC);
    check("restart_hold", alertSrc, 2'd2);
    tick(P_SEC);
    check("restart_timeout", alertSrc, 2'd0);

    // Countdown during snooze keeps the alarm pending and its snooze count
    tick(P_HIT);
    tick(P_SNZ);
    tick(P_SEC);
    tick(P_CD);
    check("snz_to_cd", alertSrc, 2'd2);
    tick(P_ACK);
    tick(P_NONE);
    check("alarm_resumes", alertSrc, 2'd1);
    tick(P_SNZ);
    check("last_snooze", alertSrc, 2'd3);
    ticks(3, P_SEC);
    check("last_resume", alertSrc, 2'd1);
    tick(P_SNZ);
    check("snz_exhausted", alertSrc, 2'd0);

    // Entry-cycle tick not counted; ack plus timeout gives IDLE
    tick(P_HIT | P_SEC);
    ticks(4, P_SEC);
    check("entry_tick_skip", alertSrc, 2'd1);
    tick(P_SEC | P_ACK);
    check("ack_timeout", alertSrc, 2'd0);

    // Editing never aborts an alert; reset discards pending requests
    tick(P_HIT);
    editing = 1'b1;
    tick(P_CD);
    check("edit_no_abort", alertSrc, 2'd1);
    Rst = 1'b1;
    tick(P_NONE);
    check("midreset_src", alertSrc, 2'd0);
    Rst = 1'b0;
    editing = 1'b0;
    ticks(2, P_NONE);
    check("pend_discarded", alertSrc, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alert_display_arbiter.md
Name: alert_display_arbiter

Overview:
- Sequences the shared 7-segment display and LED[0] between the user-selected clock mode and two asynchronous alert sources: alarm hit and countdown done.
- Sits between the mode state machine (its `Out`/`activeState` outputs) and the 7-seg driver.
- Grants the display to alerts by priority, runs per-second timeout and snooze sequencing, and defers alert entry while the user is editing a value.

Parameters:
- ALERT_SECS, 60, seconds an alert stays up before auto-dismiss (>=1)
- SNOOZE_SECS, 300, snooze duration in seconds (>=1)
- SNOOZE_MAX, 3, snoozes allowed per alarm event (>=0)

Ports:
- Clk  in  1  system clock
- Rst  in  1  synchronous, active-high reset
- secTick  in  1  one-cycle pulse per second, Clk domain
- userOut  in  32  display value from the mode state machine (seconds count or packed date)
- editing  in  1  1 while the user is in any set mode (activeState==0)
- alarmTime  in  32  programmed alarm time, shown during alarm alert
- alarmHit  in  1  one-cycle pulse: alarm matched
- cdDone  in  1  one-cycle pulse: countdown reached zero
- ackBtn  in  1  one-cycle pulse, debounced: dismiss
- snoozeBtn  in  1  one-cycle pulse, debounced: snooze
- dispOut  out  32  registered value to the 7-seg driver
- alertSrc  out  2  registered: 0 none, 1 alarm, 2 countdown, 3 snoozing
- ledBlink  out  1  registered LED[0]
- alertActive  out  1  registered: 1 in ALARM or CD

Behaviour:
- States: IDLE, ALARM, CD, SNOOZE. All outputs, state and counters are registered and update on the same Clk edge. There is no extra output pipeline: a request sampled at edge N is visible on dispOut at edge N+1.
- Reset values:
  - state IDLE, dispOut 0, alertSrc 0, ledBlink 0, alertActive 0
  - pendAlarm 0, pendCd 0, secCnt 0, snoozeUsed 0
- Pending latches:
  - Effective request is pendX | pulse.
  - A pulse arriving while its own alert is already in service (ALARM/SNOOZE for alarm, CD for countdown) is merged and dropped.
- IDLE:
  - dispOut=userOut, ledBlink=0.
  - If !editing and an alarm request is present: go to ALARM. Otherwise, if !editing and a countdown request is present: go to CD.
  - While editing=1, requests stay pending.
  - Alarm beats countdown on the same cycle; the countdown stays pending.
  - Entry to ALARM or CD clears the matching pend bit, sets secCnt=0 and sets ledBlink=1.
- ALARM:
  - dispOut=alarmTime. ledBlink toggles on each secTick. secCnt increments on secTick.
  - ackBtn: go to IDLE.
  - secTick with secCnt==ALERT_SECS-1: go to IDLE (auto-dismiss).
  - snoozeBtn with snoozeUsed<SNOOZE_MAX: go to SNOOZE, snoozeUsed+1, secCnt=0.
  - snoozeBtn with snoozeUsed==SNOOZE_MAX: acts as ack.
  - ackBtn and snoozeBtn together: ack wins.
- SNOOZE:
  - dispOut=userOut, ledBlink=0. secCnt counts secTick.
  - secTick with secCnt==SNOOZE_SECS-1: go back to ALARM with secCnt=0.
  - ackBtn: go to IDLE.
  - snoozeBtn: ignored.
  - A countdown request during SNOOZE goes to CD immediately and leaves pendAlarm set. snoozeUsed is kept, so the remaining snoozes are preserved when the alarm resumes.
- CD:
  - dispOut=32'd0 with blink, same toggle and timeout rules as ALARM.
  - snoozeBtn: acts as ack.
  - An alarm request pre-empts: go to ALARM, set pendCd, and the countdown alert restarts fresh afterwards.
- Exits to IDLE:
  - Clear snoozeUsed, except on the SNOOZE->CD path.
  - Pending requests are served from IDLE on the next cycle if editing=0.
- editing never aborts an alert already in service.
- secTick on the entry cycle is not counted.
- Timeout and ack on the same cycle both give IDLE.
- Rst mid-alert returns to IDLE and discards pending requests.
- secCnt width: $clog2(max(ALERT_SECS,SNOOZE_SECS)+1). snoozeUsed width: $clog2(SNOOZE_MAX+1), minimum 1.

Decomposition:
- Shared package holds:
  - state encoding localparams
  - ALERT_SRC codes (NONE/ALARM/CD/SNOOZE), also used by the LED/7-seg blink logic
- One sub-module: tick_timer.
  - Interface: clear, enable, secTick, limit input; outputs count and expire.
  - expire = secTick & count==limit-1.
  - Instantiated once; limit is muxed between ALERT_SECS and SNOOZE_SECS by state.

Test Plan (ALERT_SECS=5, SNOOZE_SECS=3, SNOOZE_MAX=2):
- Reset, userOut=32'd3600 -> dispOut=0 during Rst, then 3600 at the first edge after Rst falls; alertSrc=0.
- alarmHit at edge N, alarmTime=25200 -> edge N+1: dispOut=25200, alertSrc=1, ledBlink=1. ledBlink toggles on each of the next 4 secTicks. The 5th secTick returns to IDLE with dispOut=userOut.
- In ALARM, snoozeBtn x3 across cycles -> SNOOZE, ALARM after 3 ticks, SNOOZE again. The third snooze dismisses to IDLE, and snoozeUsed is back to 0 on the next alarm.
- alarmHit and cdDone on the same edge -> ALARM first. ackBtn -> IDLE for 1 cycle, then CD with dispOut=0 and alertSrc=2.
- editing=1, cdDone pulse -> stays IDLE showing userOut. editing falls -> CD on the next edge.
- In CD, alarmHit -> ALARM. ackBtn -> CD re-entered with secCnt restarted: 5 full ticks until auto-dismiss.
